// File: rtl/ov7670_capture_if.sv
// Frame-buffer write bus between the camera capture block and the dual-port frame buffer.
interface ov7670_capture_if #(
    parameter int ADDR_W = 19
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 parallel-bus receiver: pairs bytes into RGB565 pixels and writes them in raster order,
// flagging line/frame geometry errors and frame-buffer overflow.
module ov7670_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic                    pclk,
    input  logic                    rst_n,
    input  logic                    cam_vsync,
    input  logic                    cam_href,
    input  logic [7:0]              cam_d,
    input  logic                    capture_en,
    input  logic                    err_clr,
    ov7670_capture_if.master        fb,
    output logic                    frame_done,
    output logic [7:0]              frame_cnt,
    output logic                    busy,
    output logic                    err_len,
    output logic                    err_lines,
    output logic                    err_ovf
);
    localparam logic [ADDR_W:0] ADDR_END = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);
    localparam logic [15:0]     H_CNT    = 16'(H_ACTIVE);
    localparam logic [15:0]     V_CNT    = 16'(V_ACTIVE);

    typedef enum logic [1:0] {SYNC, VBLANK, FRAME} state_t;

    state_t          state;
    logic            vsync_q;
    logic            href_q;
    logic            phase;
    logic [7:0]      hi_byte;
    // One spare bit so the one-past-the-end address is representable even when 2**ADDR_W == H*V.
    logic [ADDR_W:0] addr;
    logic [15:0]     pixel_cnt;
    logic [15:0]     line_cnt;

    logic in_frame, frame_end, line_close, len_bad, lines_bad, pix_fire, ovf_hit;

    always_comb begin
        in_frame   = (state == FRAME);
        frame_end  = in_frame && cam_vsync;
        line_close = in_frame && href_q && (!cam_href || cam_vsync);
        len_bad    = phase || (pixel_cnt != H_CNT);
        lines_bad  = (line_cnt + {15'd0, line_close}) != V_CNT;
        pix_fire   = in_frame && !cam_vsync && cam_href && !href_q_fall() && phase;
        ovf_hit    = pix_fire && (addr == ADDR_END);
    end

    function automatic logic href_q_fall();
        return href_q && !cam_href;
    endfunction

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SYNC;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            phase      <= 1'b0;
            hi_byte    <= '0;
            addr       <= '0;
            pixel_cnt  <= '0;
            line_cnt   <= '0;
            fb.wr_en   <= 1'b0;
            fb.wr_addr <= '0;
            fb.wr_data <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            busy       <= 1'b0;
            err_len    <= 1'b0;
            err_lines  <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            fb.wr_en   <= 1'b0;
            frame_done <= 1'b0;
            vsync_q    <= cam_vsync;
            href_q     <= (in_frame && !cam_vsync) ? cam_href : 1'b0;

            // An error event in the same cycle as err_clr keeps its flag set.
            err_len   <= (line_close && len_bad) || (err_len && !err_clr);
            err_lines <= (frame_end && lines_bad) || (err_lines && !err_clr);
            err_ovf   <= ovf_hit || (err_ovf && !err_clr);

            case (state)
                SYNC: begin
                    if (cam_vsync) state <= VBLANK;
                end
                VBLANK: begin
                    if (vsync_q && !cam_vsync && capture_en) begin
                        state     <= FRAME;
                        busy      <= 1'b1;
                        addr      <= '0;
                        line_cnt  <= '0;
                        pixel_cnt <= '0;
                        phase     <= 1'b0;
                    end
                end
                FRAME: begin
                    if (cam_vsync) begin
                        state      <= VBLANK;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                        pixel_cnt  <= '0;
                        phase      <= 1'b0;
                    end else if (line_close) begin
                        line_cnt  <= line_cnt + 16'd1;
                        pixel_cnt <= '0;
                        phase     <= 1'b0;
                    end else if (cam_href) begin
                        if (!phase) begin
                            hi_byte <= cam_d;
                            phase   <= 1'b1;
                        end else begin
                            phase     <= 1'b0;
                            pixel_cnt <= pixel_cnt + 16'd1;
                            if (!ovf_hit) begin
                                fb.wr_en   <= 1'b1;
                                fb.wr_addr <= addr[ADDR_W-1:0];
                                fb.wr_data <= {hi_byte, cam_d};
                                addr       <= addr + (ADDR_W+1)'(1);
                            end
                        end
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end
endmodule
